// File: rtl/iserdes_dly_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : iserdes_dly_scan_if
//  Purpose  : Bundles the control, data and result signals of the read-data
//             delay calibration sequencer for one DQ/DQS lane.
//  Ports    : start/abort  - calibration request / abandon (to sequencer)
//             dout         - 4-bit deserialized ISERDES word (to sequencer)
//             dly_val/ld   - IDELAY tap value and load strobe (from sequencer)
//             busy/done    - run status and completion pulse (from sequencer)
//             fail/win_len/best_tap - calibration result (from sequencer)
//  Modports : master - training controller / lane side
//             slave  - the calibration sequencer
//  Revision : 1.0 - initial release
// ============================================================================
interface iserdes_dly_scan_if #(
    parameter int TAP_BITS = 5
);
    logic                start;
    logic                abort;
    logic [3:0]          dout;
    logic [TAP_BITS-1:0] dly_val;
    logic                dly_ld;
    logic                busy;
    logic                done;
    logic                fail;
    logic [TAP_BITS:0]   win_len;
    logic [TAP_BITS-1:0] best_tap;

    modport master (
        output start, abort, dout,
        input  dly_val, dly_ld, busy, done, fail, win_len, best_tap
    );

    modport slave (
        input  start, abort, dout,
        output dly_val, dly_ld, busy, done, fail, win_len, best_tap
    );
endinterface
`default_nettype wire

// File: rtl/iserdes_dly_scan.sv
`default_nettype none
// ============================================================================
//  Module   : iserdes_dly_scan
//  Purpose  : Sweeps the lane IDELAY tap from 0 to NUM_TAPS-1, compares the
//             deserialized word against PATTERN at every tap, tracks the
//             longest contiguous passing window and loads its centre.
//  Ports    : clk   - oclk_div, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - iserdes_dly_scan_if.slave (start, abort, dout in;
//                     dly_val, dly_ld, busy, done, fail, win_len, best_tap out)
//  Revision : 1.0 - initial release
// ============================================================================
module iserdes_dly_scan #(
    parameter int         TAP_BITS    = 5,
    parameter int         NUM_TAPS    = 32,
    parameter int         SETTLE_CYC  = 4,
    parameter int         NUM_SAMPLES = 8,
    parameter logic [3:0] PATTERN     = 4'b0101,
    parameter int         MIN_WIN     = 3,
    parameter int         DEFAULT_TAP = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    iserdes_dly_scan_if.slave  bus
);

    localparam int c_CNT_MAX = (SETTLE_CYC > NUM_SAMPLES) ? SETTLE_CYC : NUM_SAMPLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0]  c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_SAMPLE_LAST = c_CNT_W'(NUM_SAMPLES - 1);
    localparam logic [TAP_BITS-1:0] c_LAST_TAP    = TAP_BITS'(NUM_TAPS - 1);
    localparam logic [TAP_BITS-1:0] c_DEFAULT_TAP = TAP_BITS'(DEFAULT_TAP);
    localparam logic [TAP_BITS:0]   c_MIN_WIN     = (TAP_BITS + 1)'(MIN_WIN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_EVAL   = 3'd4,
        S_FINAL  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err;
    logic [TAP_BITS-1:0] r_tap;
    logic [TAP_BITS:0]   r_cur_len;
    logic [TAP_BITS-1:0] r_cur_start;
    logic [TAP_BITS:0]   r_best_len;
    logic [TAP_BITS-1:0] r_best_start;
    logic [TAP_BITS-1:0] r_dly_val;
    logic                r_dly_ld;
    logic                r_busy;
    logic                r_done;
    logic                r_fail;
    logic [TAP_BITS:0]   r_win_len;
    logic [TAP_BITS-1:0] r_best_tap;

    // Window bookkeeping for the tap being evaluated. The best-window update
    // uses the post-increment run length so a window ending on the last tap
    // is already accounted for when the centre is computed in the same cycle.
    logic                w_pass;
    logic [TAP_BITS-1:0] w_run_start;
    logic [TAP_BITS:0]   w_run_len;
    logic                w_new_best;
    logic [TAP_BITS:0]   w_best_len_nx;
    logic [TAP_BITS-1:0] w_best_start_nx;
    logic                w_win_ok;
    logic [TAP_BITS-1:0] w_half;
    logic [TAP_BITS-1:0] w_final_tap;
    logic                w_abort;

    assign w_pass          = ~r_err;
    assign w_run_start     = (r_cur_len == '0) ? r_tap : r_cur_start;
    assign w_run_len       = r_cur_len + 1'b1;
    // Strict '>' keeps the lower-tap window on a tie.
    assign w_new_best      = w_pass && (w_run_len > r_best_len);
    assign w_best_len_nx   = w_new_best ? w_run_len   : r_best_len;
    assign w_best_start_nx = w_new_best ? w_run_start : r_best_start;
    assign w_win_ok        = (w_best_len_nx >= c_MIN_WIN);
    // Centre rounds toward the lower tap for even window lengths.
    assign w_half          = TAP_BITS'((w_best_len_nx - 1'b1) >> 1);
    assign w_final_tap     = w_win_ok ? (w_best_start_nx + w_half) : c_DEFAULT_TAP;
    assign w_abort         = bus.abort && (r_state != S_IDLE) && (r_state != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_tap        <= '0;
            r_cur_len    <= '0;
            r_cur_start  <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
            r_dly_val    <= c_DEFAULT_TAP;
            r_dly_ld     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_win_len    <= '0;
            r_best_tap   <= c_DEFAULT_TAP;
        end else begin
            r_dly_ld <= 1'b0;
            r_done   <= 1'b0;
            if (w_abort) begin
                // Park the lane on the default tap; results stay untouched.
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_dly_val <= c_DEFAULT_TAP;
                r_dly_ld  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            r_tap        <= '0;
                            r_cur_len    <= '0;
                            r_cur_start  <= '0;
                            r_best_len   <= '0;
                            r_best_start <= '0;
                            r_fail       <= 1'b0;
                            r_busy       <= 1'b1;
                            // Load strobe is registered so it is high during LOAD.
                            r_dly_val    <= '0;
                            r_dly_ld     <= 1'b1;
                            r_state      <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        r_err <= 1'b0;
                        if (r_cnt == c_SETTLE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_SAMPLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        if (bus.dout != PATTERN) r_err <= 1'b1;
                        if (r_cnt == c_SAMPLE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_EVAL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_EVAL: begin
                        r_cur_len    <= w_pass ? w_run_len : '0;
                        if (w_pass) r_cur_start <= w_run_start;
                        r_best_len   <= w_best_len_nx;
                        r_best_start <= w_best_start_nx;
                        r_dly_ld     <= 1'b1;
                        if (r_tap == c_LAST_TAP) begin
                            r_dly_val <= w_final_tap;
                            r_state   <= S_FINAL;
                        end else begin
                            r_tap     <= r_tap + 1'b1;
                            r_dly_val <= r_tap + 1'b1;
                            r_state   <= S_LOAD;
                        end
                    end
                    S_FINAL: begin
                        // r_dly_val already holds the selected tap (centre or default).
                        r_best_tap <= r_dly_val;
                        r_win_len  <= r_best_len;
                        r_fail     <= (r_best_len < c_MIN_WIN);
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.dly_val  = r_dly_val;
    assign bus.dly_ld   = r_dly_ld;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.fail     = r_fail;
    assign bus.win_len  = r_win_len;
    assign bus.best_tap = r_best_tap;

endmodule
`default_nettype wire
